// File: rtl/vga_spi_pkg.sv
// Pixel packing and SPI command bytes shared by the frame master and the
// display-side receiver.
package vga_spi_pkg;

    localparam int PX_R_W = 2;
    localparam int PX_G_W = 2;
    localparam int PX_B_W = 2;
    localparam int PX_W   = PX_R_W + PX_G_W + PX_B_W;

    localparam logic [7:0] CMD_ALIGN = 8'h80;
    localparam logic [7:0] CMD_SWAP  = 8'h81;

    typedef enum logic [1:0] {
        BYTE_ALIGN,
        BYTE_PIXEL,
        BYTE_SWAP
    } byte_sel_t;

    // Pixels travel as {2'b00, R, G, B} so they can never alias a command byte.
    function automatic logic [7:0] pack_pixel(input logic [PX_W-1:0] px);
        return {{(8 - PX_W){1'b0}}, px};
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// SPI mode-0 byte shifter: clock divider plus 8-bit MSB-first shift register.
// start loads data_in; done pulses for one cycle after bit 0's high phase.
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] data_in,
    output logic       sclk,
    output logic       mosi,
    output logic       done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    // mosi is the shift register MSB, so it only moves on the edges where
    // the register loads or shifts, both of which leave sclk low.
    assign mosi = shreg[7];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous and clears the datapath too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            done    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                active  <= 1'b0;
                sclk    <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (start && !active) begin
                active  <= 1'b1;
                sclk    <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= 3'd7;
                shreg   <= data_in;
            end else if (active) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                            active <= 1'b0;
                            done   <= 1'b1;
                            shreg  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// Streams one video frame over SPI: CMD_ALIGN, RES_X*RES_Y pixel bytes,
// CMD_SWAP, with chip-select framing, inter-byte gaps and abort.
module spi_frame_master
    import vga_spi_pkg::*;
#(
    parameter int RES_X      = 320,
    parameter int RES_Y      = 240,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_frame,
    input  logic                              abort,
    input  logic                              px_valid,
    input  logic [PX_W-1:0]                   px_data,
    output logic                              px_ready,
    output logic                              sclk,
    output logic                              cs_n,
    output logic                              mosi,
    output logic                              busy,
    output logic                              frame_done,
    // One extra code so the count can actually reach RES_X*RES_Y.
    output logic [$clog2(RES_X*RES_Y+1)-1:0]  pix_count
);

    localparam int NUM_PIX = RES_X * RES_Y;
    localparam int PIX_W   = $clog2(NUM_PIX + 1);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_DIV);
    localparam logic [PIX_W-1:0] PIX_FULL   = PIX_W'(NUM_PIX);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CS_SETUP = 3'd1;
    localparam logic [2:0] LOAD     = 3'd2;
    localparam logic [2:0] SHIFT    = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;
    localparam logic [2:0] CS_HOLD  = 3'd5;

    logic [2:0]       state;
    byte_sel_t        byte_sel;
    logic [CNT_W-1:0] cnt;
    logic             pixel_load;
    logic             tx_start;
    logic             tx_done;
    logic [7:0]       tx_data;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        pixel_load = (state == LOAD) && (byte_sel == BYTE_PIXEL);
        px_ready   = pixel_load && !abort;
        tx_start   = (state == LOAD) && !abort && (!pixel_load || px_valid);
        tx_data    = CMD_SWAP;
        case (byte_sel)
            BYTE_ALIGN: tx_data = CMD_ALIGN;
            BYTE_PIXEL: tx_data = pack_pixel(px_data);
            default:    tx_data = CMD_SWAP;
        endcase
    end

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .clear   (abort),
        .data_in (tx_data),
        .sclk    (sclk),
        .mosi    (mosi),
        .done    (tx_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_sel   <= BYTE_ALIGN;
            cnt        <= '0;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pix_count  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                cs_n  <= 1'b1;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_frame && !abort) begin
                            state     <= CS_SETUP;
                            cs_n      <= 1'b0;
                            busy      <= 1'b1;
                            pix_count <= '0;
                            byte_sel  <= BYTE_ALIGN;
                            cnt       <= '0;
                        end
                    end
                    CS_SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            state <= LOAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOAD: begin
                        if (tx_start) begin
                            state <= SHIFT;
                            if (pixel_load && pix_count != PIX_FULL)
                                pix_count <= pix_count + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (tx_done) begin
                            cnt <= '0;
                            if (byte_sel == BYTE_SWAP) begin
                                state <= CS_HOLD;
                            end else begin
                                state <= GAP;
                                // pix_count already includes the byte just sent.
                                if (byte_sel == BYTE_ALIGN || pix_count != PIX_FULL)
                                    byte_sel <= BYTE_PIXEL;
                                else
                                    byte_sel <= BYTE_SWAP;
                            end
                        end
                    end
                    GAP: begin
                        if (cnt == GAP_LAST) begin
                            state <= LOAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    CS_HOLD: begin
                        // CLK_DIV cycles with cs_n low, then one frame_done cycle
                        // that still counts as busy so a same-cycle start is ignored.
                        if (cnt == HOLD_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            if (cnt == SETUP_LAST) begin
                                cs_n       <= 1'b1;
                                frame_done <= 1'b1;
                            end
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed frame scenarios with random pixel data, checked by an SPI slave
// model and a byte-stream reference computed from the frame format rules.
module tb_spi_frame_master;

    localparam int RES_X      = 4;
    localparam int RES_Y      = 2;
    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 4;
    localparam int NUM_PIX    = RES_X * RES_Y;
    localparam int PIX_W      = $clog2(NUM_PIX + 1);
    localparam int T          = 10;
    localparam int BIT_STEP   = 2 * CLK_DIV;
    // Last rise to next byte's first rise: high tail, done cycle, GAP, LOAD, low phase.
    localparam int BYTE_STEP  = 2 * CLK_DIV + GAP_CYCLES + 2;
    localparam int FRAME_BYTES = NUM_PIX + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_frame;
    logic             abort;
    logic             px_valid;
    logic [5:0]       px_data;
    logic             px_ready;
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             busy;
    logic             frame_done;
    logic [PIX_W-1:0] pix_count;

    always #(T / 2) clk = ~clk;

    spi_frame_master #(
        .RES_X      (RES_X),
        .RES_Y      (RES_Y),
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_frame (start_frame),
        .abort       (abort),
        .px_valid    (px_valid),
        .px_data     (px_data),
        .px_ready    (px_ready),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .busy        (busy),
        .frame_done  (frame_done),
        .pix_count   (pix_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SPI slave: samples mosi on sclk rising, realigns whenever cs_n falls.
    logic [7:0] rx_q[$];
    longint     rise_q[$];
    int         cs_epoch = 0;

    initial begin : slave
        int         nbits;
        int         seen_epoch;
        logic [7:0] sh;
        nbits = 0;
        seen_epoch = 0;
        sh = 8'h00;
        forever begin
            @(posedge sclk);
            if (seen_epoch != cs_epoch) begin
                nbits = 0;
                seen_epoch = cs_epoch;
            end
            rise_q.push_back(longint'($time));
            if (!cs_n) begin
                sh = {sh[6:0], mosi};
                nbits++;
                if (nbits == 8) begin
                    rx_q.push_back(sh);
                    nbits = 0;
                end
            end
        end
    end

    int hi_bad = 0;
    int mosi_bad = 0;
    int stall_bad = 0;
    int stall_cycles = 0;
    int done_cnt = 0;

    initial begin : monitor
        logic sclk_q, mosi_q, cs_q;
        int   hi_run;
        sclk_q = 1'b0;
        mosi_q = 1'b0;
        cs_q = 1'b1;
        hi_run = 0;
        forever begin
            @(negedge clk);
            if (cs_q && !cs_n) cs_epoch++;
            if (sclk) begin
                hi_run++;
            end else begin
                if (sclk_q && hi_run != CLK_DIV) hi_bad++;
                hi_run = 0;
            end
            if (sclk && mosi !== mosi_q) mosi_bad++;
            if (px_ready && !px_valid) begin
                stall_cycles++;
                if (sclk || cs_n) stall_bad++;
            end
            if (frame_done) done_cnt++;
            sclk_q = sclk;
            mosi_q = mosi;
            cs_q = cs_n;
        end
    end

    // Pixel source: presents pix_mem[feed_idx], advancing on each handshake.
    logic [5:0] pix_mem[NUM_PIX];
    int         feed_idx = 0;
    bit         feed_on = 1'b0;
    int         stall_at = -1;
    int         stall_left = 0;

    initial begin : feeder
        bit took;
        px_valid = 1'b0;
        px_data = 6'd0;
        forever begin
            @(posedge clk);
            took = px_valid && px_ready;
            @(negedge clk);
            if (took) feed_idx++;
            if (feed_idx == stall_at && stall_left > 0) begin
                px_valid = 1'b0;
                stall_left--;
            end else begin
                px_valid = feed_on;
            end
            px_data = pix_mem[feed_idx % NUM_PIX];
        end
    end

    task automatic prime_feed(input bit stalled);
        feed_idx = 0;
        feed_on = 1'b1;
        stall_at = stalled ? 3 : -1;
        stall_left = stalled ? 100 : 0;
    endtask

    task automatic run_frame(input string name, input bit stalled, input bit poke);
        logic [7:0] exp_q[$];
        int rx0, rs0, hb0, mb0, sb0, sc0, dn0, c, bad, k, idx;
        exp_q.push_back(8'h80);
        for (int i = 0; i < NUM_PIX; i++) exp_q.push_back({2'b00, pix_mem[i]});
        exp_q.push_back(8'h81);
        rx0 = rx_q.size();
        rs0 = rise_q.size();
        hb0 = hi_bad;
        mb0 = mosi_bad;
        sb0 = stall_bad;
        sc0 = stall_cycles;
        dn0 = done_cnt;
        prime_feed(stalled);

        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        check({name, ":busy_on"}, busy, 1);
        check({name, ":cs_low"}, cs_n, 0);

        c = 0;
        while (!frame_done && c < 3000) begin
            @(negedge clk);
            c++;
            start_frame = poke && (c == 100);
        end
        check({name, ":done_seen"}, frame_done, 1);
        check({name, ":cs_high_at_done"}, cs_n, 1);
        check({name, ":busy_at_done"}, busy, 1);
        start_frame = poke;
        @(negedge clk);
        start_frame = 1'b0;
        check({name, ":busy_off"}, busy, 0);
        repeat (20) @(negedge clk);
        check({name, ":still_idle"}, busy, 0);

        check({name, ":pix_count"}, 32'(pix_count), NUM_PIX);
        check({name, ":pixels_taken"}, feed_idx, NUM_PIX);
        check({name, ":byte_count"}, rx_q.size() - rx0, FRAME_BYTES);
        for (int i = 0; i < FRAME_BYTES; i++) begin
            idx = rx0 + i;
            check($sformatf("%s:byte%0d", name, i),
                  (idx < rx_q.size()) ? rx_q[idx] : 8'hxx, exp_q[i]);
        end
        check({name, ":sclk_rises"}, rise_q.size() - rs0, 8 * FRAME_BYTES);
        check({name, ":frame_done_pulses"}, done_cnt - dn0, 1);
        check({name, ":high_phase"}, hi_bad - hb0, 0);
        check({name, ":mosi_stable"}, mosi_bad - mb0, 0);

        bad = 0;
        for (int i = rs0 + 1; i < rise_q.size(); i++) begin
            k = i - rs0;
            if (k % 8 != 0) begin
                if ((rise_q[i] - rise_q[i-1]) != longint'(BIT_STEP * T)) bad++;
            end else if (!(stalled && k == 32)) begin
                if ((rise_q[i] - rise_q[i-1]) != longint'(BYTE_STEP * T)) bad++;
            end
        end
        check({name, ":rise_spacing"}, bad, 0);
        if (stalled) begin
            check({name, ":stall_lines_idle"}, stall_bad - sb0, 0);
            check({name, ":stall_observed"}, 32'(stall_cycles - sc0 >= 50), 1);
        end
    endtask

    initial begin : main
        int rs0, dn0, c;
        rst = 1'b1;
        start_frame = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 6'(i);
        repeat (3) @(negedge clk);
        check("reset:sclk", sclk, 0);
        check("reset:cs_n", cs_n, 1);
        check("reset:mosi", mosi, 0);
        check("reset:px_ready", px_ready, 0);
        check("reset:busy", busy, 0);
        check("reset:frame_done", frame_done, 0);
        check("reset:pix_count", 32'(pix_count), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("ramp", 1'b0, 1'b0);

        for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 6'($urandom);
        run_frame("stall", 1'b1, 1'b0);

        // Abort during bit 4 of pixel 2 (the 28th sclk rise of the frame).
        for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 6'($urandom);
        prime_feed(1'b0);
        rs0 = rise_q.size();
        dn0 = done_cnt;
        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        c = 0;
        while (rise_q.size() - rs0 < 28 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("abort:reached_bit4", rise_q.size() - rs0, 28);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort:cs_n", cs_n, 1);
        check("abort:sclk", sclk, 0);
        check("abort:mosi", mosi, 0);
        check("abort:busy", busy, 0);
        check("abort:px_ready", px_ready, 0);
        repeat (40) @(negedge clk);
        check("abort:no_done", done_cnt - dn0, 0);
        check("abort:pix_count", 32'(pix_count), 3);
        check("abort:pixels_taken", feed_idx, 3);
        check("abort:no_more_rises", rise_q.size() - rs0, 28);

        for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 6'($urandom);
        run_frame("restart", 1'b0, 1'b0);

        // start and abort together in IDLE must not start a frame.
        rs0 = rise_q.size();
        start_frame = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        abort = 1'b0;
        check("start_abort:busy", busy, 0);
        check("start_abort:cs_n", cs_n, 1);
        repeat (10) @(negedge clk);
        check("start_abort:no_rises", rise_q.size() - rs0, 0);

        for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 6'($urandom);
        run_frame("ignored_starts", 1'b0, 1'b1);

        // Asynchronous reset in the middle of a pixel byte.
        for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 6'($urandom);
        prime_feed(1'b0);
        rs0 = rise_q.size();
        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        c = 0;
        while (rise_q.size() - rs0 < 13 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid:reached_shift", rise_q.size() - rs0, 13);
        #(T / 4) rst = 1'b1;
        #1;
        check("rst_mid:sclk", sclk, 0);
        check("rst_mid:cs_n", cs_n, 1);
        check("rst_mid:mosi", mosi, 0);
        check("rst_mid:px_ready", px_ready, 0);
        check("rst_mid:busy", busy, 0);
        check("rst_mid:frame_done", frame_done, 0);
        check("rst_mid:pix_count", 32'(pix_count), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NUM_PIX; i++) pix_mem[i] = 6'($urandom);
        run_frame("after_reset", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
